// File: rtl/amp_pkg.sv
// Shared constants and state encoding for the LTC6912-1 preamp controller.
package amp_pkg;

    localparam logic [3:0]  GAIN_MIN = 4'd1;
    localparam logic [3:0]  GAIN_MAX = 4'd7;
    localparam int unsigned AMP_BITS = 8;

    typedef enum logic [2:0] {
        INIT_HI,
        INIT_LO,
        IDLE,
        REQ,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD
    } amp_state_e;

    function automatic logic gain_ok(input logic [3:0] g);
        return (g >= GAIN_MIN) && (g <= GAIN_MAX);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period tick generator: one rise/fall strobe every CLK_DIV cycles while enabled.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          lvl_q, lvl_d;
    logic          tick;

    assign tick   = en_i && (div_q == DW'(CLK_DIV - 1));
    assign rise_o = tick && !lvl_q;
    assign fall_o = tick && lvl_q;

    // The caller raises SCK itself on the cycle it enables us, so idle presets the level high.
    always_comb begin
        div_d = div_q;
        lvl_d = lvl_q;
        if (!en_i) begin
            div_d = '0;
            lvl_d = 1'b1;
        end else if (tick) begin
            div_d = '0;
            lvl_d = !lvl_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            lvl_q <= 1'b1;
        end else begin
            div_q <= div_d;
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/amp_ltc6912_ctrl.sv
// LTC6912-1 gain controller: SHDN init pulse, then one 8-bit SPI write per request
// with readback of the amp's previous setting.
module amp_ltc6912_ctrl
    import amp_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned SHDN_CYCLES = 4,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned CS_HOLD     = 2
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] gain_a,
    input  logic [3:0] gain_b,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       AMP_CS,
    output logic       AMP_SHDN,
    input  logic       AMP_DOUT
);

    amp_state_e          state_q, state_d;
    logic [15:0]         tmr_q, tmr_d;
    logic [3:0]          bit_q, bit_d;
    logic [AMP_BITS-1:0] sh_q, sh_d, rx_q, rx_d, rd_q, rd_d;
    logic                cs_q, cs_d, shdn_q, shdn_d, sck_q, sck_d, mosi_q, mosi_d;
    logic                req_q, req_d, done_q, done_d, err_q, err_d;
    logic                sck_en, sck_rise, sck_fall;

    assign sck_en = (state_q == SCK_HI) || (state_q == SCK_LO);

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk_i (CLK50MHZ),
        .rst_i (RST),
        .en_i  (sck_en),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        cs_d    = cs_q;
        shdn_d  = shdn_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            INIT_HI: begin
                shdn_d = 1'b1;
                tmr_d  = tmr_q + 1'b1;
                if (tmr_q == 16'(SHDN_CYCLES)) begin
                    shdn_d  = 1'b0;
                    tmr_d   = '0;
                    state_d = INIT_LO;
                end
            end
            INIT_LO: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == 16'(SHDN_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                tmr_d = '0;
                bit_d = '0;
                if (start) begin
                    if (gain_ok(gain_a) && gain_ok(gain_b)) begin
                        sh_d    = {gain_a, gain_b};
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = sh_q[AMP_BITS-1];
                    tmr_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == 16'(CS_SETUP - 1)) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[AMP_BITS-2:0], AMP_DOUT};
                    bit_d   = bit_q + 1'b1;
                    state_d = SCK_HI;
                end
            end
            SCK_HI: begin
                if (sck_fall) begin
                    sck_d   = 1'b0;
                    sh_d    = {sh_q[AMP_BITS-2:0], 1'b0};
                    mosi_d  = sh_q[AMP_BITS-2];
                    state_d = SCK_LO;
                end
            end
            SCK_LO: begin
                // The last low half-period is completed before HOLD so the byte spans 16 half-periods.
                if (sck_rise) begin
                    if (bit_q == 4'(AMP_BITS)) begin
                        tmr_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sck_d   = 1'b1;
                        rx_d    = {rx_q[AMP_BITS-2:0], AMP_DOUT};
                        bit_d   = bit_q + 1'b1;
                        state_d = SCK_HI;
                    end
                end
            end
            HOLD: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == 16'(CS_HOLD - 1)) begin
                    cs_d    = 1'b1;
                    req_d   = 1'b0;
                    mosi_d  = 1'b0;
                    rd_d    = rx_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = INIT_HI;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q <= INIT_HI;
            tmr_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            cs_q    <= 1'b1;
            shdn_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            shdn_q  <= shdn_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = rd_q;
    assign bus_req  = req_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign AMP_CS   = cs_q;
    assign AMP_SHDN = shdn_q;

endmodule
